keccak_byte_packer: RTL and testbench
=====================================

KECCAK_BYTE_PACKER -- requirements
Module: keccak_byte_packer

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: s_data  input  8  message byte from source.
REQ-004 SHALL: s_valid  input  1  s_data/s_last/s_nobyte valid this cycle.
REQ-005 SHALL: s_last  input  1  beat is the final beat of the message.
REQ-006 SHALL: s_nobyte  input  1  beat carries no data byte; legal only with s_last=1 (zero-length tail).
REQ-007 SHALL: s_ready  output  1  packer accepts a beat this cycle; beat transfers when s_valid&&s_ready.
REQ-008 SHALL: k_in  output  32  word to keccak core; first-received byte in bits 31:24.
REQ-009 SHALL: k_in_ready  output  1  k_in valid.
REQ-010 SHALL: k_is_last  output  1  word is the message's final word.
REQ-011 SHALL: k_byte_num  output  2  count of valid bytes in k_in when k_is_last=1; else 0.
REQ-012 SHALL: k_buffer_full  input  1  core cannot accept; word transfers on a rising edge where k_in_ready=1 and k_buffer_full=0.

Function
REQ-013 SHALL: states ACC, SEND, SEND_LAST, SEND_EMPTY, DONE; 2-bit byte count cnt (0..3) plus 32-bit accumulator acc.
REQ-014 SHALL: in ACC, s_ready=1, k_in_ready=0; each data beat writes s_data into byte lane (3-cnt) of acc and increments cnt.
REQ-015 SHALL: non-last beat with cnt=3 -> SEND with 4-byte word; cnt wraps to 0.
REQ-016 SHALL: last data beat with resulting count n<4 -> SEND_LAST, k_byte_num=n, unused lanes zero.
REQ-017 SHALL: last data beat with resulting count 4 -> SEND (full word), then SEND_EMPTY (k_in=0, k_is_last=1, k_byte_num=0).
REQ-018 SHALL: s_nobyte&&s_last beat -> SEND_LAST with k_byte_num=cnt (0 for empty message or 4-aligned message); s_data ignored.
REQ-019 SHALL: in SEND/SEND_LAST/SEND_EMPTY, s_ready=0, k_in_ready=1, k_in held stable until transfer.
REQ-020 SHALL: k_is_last=1 only in SEND_LAST/SEND_EMPTY; never with k_in_ready=0.
REQ-021 SHALL: SEND transfer -> ACC, or SEND_EMPTY if pending tail; SEND_LAST/SEND_EMPTY transfer -> DONE.
REQ-022 SHALL: k_buffer_full=1 stalls indefinitely with all outputs held; no word lost or duplicated.
REQ-023 SHALL: DONE holds s_ready=0, k_in_ready=0 until reset (one message per reset, matching core).
REQ-024 SHALL: s_nobyte with s_last=0 is ignored (beat accepted, no state change).

Reset
REQ-025 SHALL: reset (synchronous, dominant over all other inputs) -> state ACC, cnt=0, acc=0, k_in=0, k_in_ready=0, k_is_last=0, k_byte_num=0, s_ready=1 next cycle.
REQ-026 SHALL: reset mid-word or mid-stall discards partial data; no word emitted after reset edge.

Structure
REQ-027 SHALL: state encoding enum and constants (WORD_BYTES=4, byte lane width 8) live in shared package keccak_pkg.
REQ-028 SHALL: single flat module, no sub-module; all outputs registered or decoded from registered state.

Verification
REQ-029 SHALL: bytes 61 62 63 last, buffer_full=0 -> one word k_in=0x61626300, k_is_last=1, k_byte_num=3, then DONE.
REQ-030 SHALL: bytes 01..08, 08 last -> words 0x01020304, 0x05060708, then 0x00000000 k_is_last=1 k_byte_num=0.
REQ-031 SHALL: single beat s_nobyte=1 s_last=1 -> one word 0x00000000, k_is_last=1, k_byte_num=0.
REQ-032 SHALL: k_buffer_full=1 for 10 cycles while word 0xAABBCCDD pending -> k_in/k_in_ready held 10 cycles, s_ready=0, word transferred once when released.
REQ-033 SHALL: reset asserted after 2 of 4 bytes -> next message 11 22 33 44 55(last) yields 0x11223344 then 0x55000000 byte_num=1, no stale bytes.
REQ-034 SHALL: random 0..300-byte messages with random s_valid/k_buffer_full -> reassembled byte stream from k_in/k_byte_num equals source, exactly one k_is_last.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak byte packer: state encoding, word geometry,
// and the byte-lane insertion helper.
package keccak_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned LANE_W     = 8;
   localparam int unsigned WORD_W     = WORD_BYTES * LANE_W;
   localparam logic [2:0]  FULL_CNT   = 3'(WORD_BYTES);

   typedef enum logic [2:0] {
      ST_ACC        = 3'd0,
      ST_SEND       = 3'd1,
      ST_SEND_LAST  = 3'd2,
      ST_SEND_EMPTY = 3'd3,
      ST_DONE       = 3'd4
   } state_e;

   // Byte 0 of a word lands in the most significant lane.
   function automatic logic [WORD_W-1:0] lane_insert(input logic [WORD_W-1:0] word,
                                                     input logic [1:0]        cnt,
                                                     input logic [LANE_W-1:0] b);
      logic [WORD_W-1:0] r;
      r = word;
      case (cnt)
         2'd0:    r[31:24] = b;
         2'd1:    r[23:16] = b;
         2'd2:    r[15:8]  = b;
         2'd3:    r[7:0]   = b;
         default: r        = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs a byte stream into 32-bit words for the Keccak core, marking the final
// word and its valid byte count; handles one message per reset.
module keccak_byte_packer
   import keccak_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [LANE_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   input  logic              s_nobyte,
   output logic              s_ready,
   output logic [WORD_W-1:0] k_in,
   output logic              k_in_ready,
   output logic              k_is_last,
   output logic [1:0]        k_byte_num,
   input  logic              k_buffer_full
);

   state_e            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [WORD_W-1:0] acc_q, acc_d;
   logic              tail_q, tail_d;
   logic [WORD_W-1:0] k_in_q, k_in_d;
   logic              k_in_ready_q, k_in_ready_d;
   logic              k_is_last_q, k_is_last_d;
   logic [1:0]        k_byte_num_q, k_byte_num_d;

   logic [WORD_W-1:0] acc_wr_s;
   logic [2:0]        n_s;

   assign s_ready    = (state_q == ST_ACC);
   assign k_in       = k_in_q;
   assign k_in_ready = k_in_ready_q;
   assign k_is_last  = k_is_last_q;
   assign k_byte_num = k_byte_num_q;

   // Next-state and next-output computation; acc is cleared whenever a word
   // leaves it so unused lanes of a short final word read as zero.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      tail_d       = tail_q;
      k_in_d       = k_in_q;
      k_in_ready_d = k_in_ready_q;
      k_is_last_d  = k_is_last_q;
      k_byte_num_d = k_byte_num_q;
      acc_wr_s     = lane_insert(acc_q, cnt_q, s_data);
      n_s          = {1'b0, cnt_q} + 3'd1;

      case (state_q)
         ST_ACC: begin
            if (s_valid) begin
               if (s_nobyte) begin
                  if (s_last) begin
                     state_d      = ST_SEND_LAST;
                     k_in_d       = acc_q;
                     k_in_ready_d = 1'b1;
                     k_is_last_d  = 1'b1;
                     k_byte_num_d = cnt_q;
                     acc_d        = 32'h0000_0000;
                     cnt_d        = 2'd0;
                  end else begin
                     state_d = ST_ACC;
                  end
               end else if (s_last || (n_s == FULL_CNT)) begin
                  k_in_d       = acc_wr_s;
                  k_in_ready_d = 1'b1;
                  acc_d        = 32'h0000_0000;
                  cnt_d        = 2'd0;
                  if (s_last && (n_s != FULL_CNT)) begin
                     state_d      = ST_SEND_LAST;
                     k_is_last_d  = 1'b1;
                     k_byte_num_d = n_s[1:0];
                  end else begin
                     // A full final word still needs an empty terminator word.
                     state_d      = ST_SEND;
                     tail_d       = s_last;
                     k_is_last_d  = 1'b0;
                     k_byte_num_d = 2'd0;
                  end
               end else begin
                  acc_d = acc_wr_s;
                  cnt_d = n_s[1:0];
               end
            end else begin
               state_d = ST_ACC;
            end
         end
         ST_SEND: begin
            if (!k_buffer_full) begin
               k_in_d       = 32'h0000_0000;
               k_byte_num_d = 2'd0;
               tail_d       = 1'b0;
               if (tail_q) begin
                  state_d      = ST_SEND_EMPTY;
                  k_in_ready_d = 1'b1;
                  k_is_last_d  = 1'b1;
               end else begin
                  state_d      = ST_ACC;
                  k_in_ready_d = 1'b0;
                  k_is_last_d  = 1'b0;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_SEND_LAST, ST_SEND_EMPTY: begin
            if (!k_buffer_full) begin
               state_d      = ST_DONE;
               k_in_d       = 32'h0000_0000;
               k_in_ready_d = 1'b0;
               k_is_last_d  = 1'b0;
               k_byte_num_d = 2'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d      = ST_ACC;
            cnt_d        = 2'd0;
            acc_d        = 32'h0000_0000;
            tail_d       = 1'b0;
            k_in_d       = 32'h0000_0000;
            k_in_ready_d = 1'b0;
            k_is_last_d  = 1'b0;
            k_byte_num_d = 2'd0;
         end
      endcase
   end

   // State and output registers with dominant synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_ACC;
         cnt_q        <= 2'd0;
         acc_q        <= 32'h0000_0000;
         tail_q       <= 1'b0;
         k_in_q       <= 32'h0000_0000;
         k_in_ready_q <= 1'b0;
         k_is_last_q  <= 1'b0;
         k_byte_num_q <= 2'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         tail_q       <= tail_d;
         k_in_q       <= k_in_d;
         k_in_ready_q <= k_in_ready_d;
         k_is_last_q  <= k_is_last_d;
         k_byte_num_q <= k_byte_num_d;
      end
   end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Self-checking bench: directed cases plus randomized messages compared against
// a word-list model derived from the message bytes.
module tb_keccak_byte_packer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic        s_nobyte = 1'b0;
   logic        s_ready;
   logic [31:0] k_in;
   logic        k_in_ready;
   logic        k_is_last;
   logic [1:0]  k_byte_num;
   logic        k_buffer_full = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   int idle_pct = 0;
   int full_pct = 0;
   logic full_rand = 1'b0;

   logic [7:0]  msg[$];
   logic [31:0] exp_word[$];
   logic        exp_last[$];
   logic [1:0]  exp_bn[$];
   logic [31:0] got_word[$];
   logic        got_last[$];
   logic [1:0]  got_bn[$];
   int          got_last_cnt = 0;

   logic        prev_stall = 1'b0;
   logic [31:0] prev_k_in;
   logic        prev_last;
   logic [1:0]  prev_bn;

   keccak_byte_packer dut (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_nobyte(s_nobyte), .s_ready(s_ready), .k_in(k_in), .k_in_ready(k_in_ready),
      .k_is_last(k_is_last), .k_byte_num(k_byte_num), .k_buffer_full(k_buffer_full)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Core-side backpressure generator.
   always @(negedge clk) begin
      if (full_rand) k_buffer_full = ($urandom_range(0, 99) < full_pct);
   end

   // Output monitor: records transferred words and checks hold-during-stall.
   always @(posedge clk) begin
      if (!reset) begin
         if (prev_stall) begin
            check_eq("hold_rdy", {31'd0, k_in_ready}, 32'd1);
            check_eq("hold_kin", k_in, prev_k_in);
            check_eq("hold_last", {31'd0, k_is_last}, {31'd0, prev_last});
            check_eq("hold_bn", {30'd0, k_byte_num}, {30'd0, prev_bn});
         end
         if (k_is_last) check_eq("last_wo_rdy", {31'd0, k_in_ready}, 32'd1);
         if (k_in_ready && !k_is_last) check_eq("bn_not_last", {30'd0, k_byte_num}, 32'd0);
         if (k_in_ready && !k_buffer_full) begin
            got_word.push_back(k_in);
            got_last.push_back(k_is_last);
            got_bn.push_back(k_byte_num);
            if (k_is_last) got_last_cnt++;
         end
         prev_stall = k_in_ready && k_buffer_full;
         prev_k_in  = k_in;
         prev_last  = k_is_last;
         prev_bn    = k_byte_num;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_nobyte = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      got_word.delete(); got_last.delete(); got_bn.delete(); got_last_cnt = 0;
      check_eq("rst_kin", k_in, 32'h0);
      check_eq("rst_rdy", {31'd0, k_in_ready}, 32'd0);
      check_eq("rst_last", {31'd0, k_is_last}, 32'd0);
      check_eq("rst_bn", {30'd0, k_byte_num}, 32'd0);
      check_eq("rst_sready", {31'd0, s_ready}, 32'd1);
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l, input logic nb);
      int t;
      @(negedge clk);
      while ($urandom_range(0, 99) < idle_pct) begin
         s_valid = 1'b0; s_data = 8'($urandom);
         @(negedge clk);
      end
      s_valid = 1'b1; s_data = d; s_last = l; s_nobyte = nb;
      t = 0;
      while (!s_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) check_eq("src_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0; s_last = 1'b0; s_nobyte = 1'b0;
   endtask

   // Reference: full 4-byte words, then one final word holding the 0..3 leftover bytes.
   task automatic build_expected();
      int i;
      int r;
      logic [31:0] w;
      exp_word.delete(); exp_last.delete(); exp_bn.delete();
      i = 0;
      while (i + 4 <= msg.size()) begin
         exp_word.push_back({msg[i], msg[i+1], msg[i+2], msg[i+3]});
         exp_last.push_back(1'b0);
         exp_bn.push_back(2'd0);
         i += 4;
      end
      r = msg.size() - i;
      w = 32'h0;
      for (int j = 0; j < r; j++) w[31-8*j -: 8] = msg[i+j];
      exp_word.push_back(w);
      exp_last.push_back(1'b1);
      exp_bn.push_back(2'(r));
   endtask

   task automatic finish_msg(input string tag);
      int t;
      int nb;
      t = 0;
      while (got_last_cnt == 0 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      repeat (3) @(negedge clk);
      check_eq({tag, "_done_sready"}, {31'd0, s_ready}, 32'd0);
      check_eq({tag, "_done_rdy"}, {31'd0, k_in_ready}, 32'd0);
      check_eq({tag, "_nlast"}, 32'(got_last_cnt), 32'd1);
      build_expected();
      check_eq({tag, "_nwords"}, 32'(got_word.size()), 32'(exp_word.size()));
      nb = 0;
      for (int i = 0; i < got_word.size() && i < exp_word.size(); i++) begin
         check_eq({tag, "_word"}, got_word[i], exp_word[i]);
         check_eq({tag, "_islast"}, {31'd0, got_last[i]}, {31'd0, exp_last[i]});
         check_eq({tag, "_bn"}, {30'd0, got_bn[i]}, {30'd0, exp_bn[i]});
         nb += got_last[i] ? int'(got_bn[i]) : 4;
      end
      check_eq({tag, "_nbytes"}, 32'(nb), 32'(msg.size()));
   endtask

   task automatic send_msg(input logic nobyte_tail, input logic junk);
      for (int k = 0; k < msg.size(); k++) begin
         if (junk && $urandom_range(0, 99) < 10) send_beat(8'($urandom), 1'b0, 1'b1);
         send_beat(msg[k], (k == msg.size() - 1) && !nobyte_tail, 1'b0);
      end
      if (nobyte_tail) send_beat(8'($urandom), 1'b1, 1'b1);
   endtask

   initial begin
      int len;
      int t;
      do_reset();

      // Short message, three bytes
      msg = '{8'h61, 8'h62, 8'h63};
      send_msg(1'b0, 1'b0);
      finish_msg("abc");

      // Eight bytes: two full words then an empty terminator
      do_reset();
      msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_msg(1'b0, 1'b0);
      finish_msg("eight");

      // Empty message
      do_reset();
      msg.delete();
      send_msg(1'b1, 1'b0);
      finish_msg("empty");

      // Ten-cycle stall on a pending full word
      do_reset();
      k_buffer_full = 1'b1;
      msg = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      for (int k = 0; k < 4; k++) send_beat(msg[k], 1'b0, 1'b0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_eq("stall_kin", k_in, 32'hAABBCCDD);
         check_eq("stall_rdy", {31'd0, k_in_ready}, 32'd1);
         check_eq("stall_sready", {31'd0, s_ready}, 32'd0);
      end
      k_buffer_full = 1'b0;
      @(negedge clk);
      check_eq("stall_once", 32'(got_word.size()), 32'd1);
      check_eq("stall_released", {31'd0, k_in_ready}, 32'd0);
      send_beat(8'h00, 1'b1, 1'b1);
      finish_msg("stall");

      // Reset part way through a word discards the partial bytes
      do_reset();
      send_beat(8'hEE, 1'b0, 1'b0);
      send_beat(8'hFF, 1'b0, 1'b0);
      do_reset();
      msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      send_msg(1'b0, 1'b0);
      finish_msg("midrst");

      // Randomized messages with random gaps and backpressure
      for (int m = 0; m < 14; m++) begin
         do_reset();
         len = (m < 4) ? m : $urandom_range(0, 300);
         msg.delete();
         for (int k = 0; k < len; k++) msg.push_back(8'($urandom));
         idle_pct  = $urandom_range(0, 40);
         full_pct  = $urandom_range(0, 60);
         full_rand = 1'b1;
         send_msg((len == 0) || ($urandom_range(0, 1) == 1), 1'b1);
         finish_msg("rand");
         full_rand = 1'b0;
         k_buffer_full = 1'b0;
      end

      t = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
